// File: rtl/idli_pkg.sv
// idli_pkg: shared types and defaults for the idli core UART transmit path.
//   sqi_data_t      - one nibble of the nibble-serial ALU stream
//   uart_tx_state_t - transmitter frame states
package idli_pkg;
    typedef logic [3:0] sqi_data_t;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
    localparam int UART_DATA_W_DFLT  = 8;
    localparam int UART_CLK_DIV_DFLT = 16;
endpackage

// File: rtl/idli_uart_fifo_m.sv
// idli_uart_fifo_m: synchronous FIFO with full/empty flags and occupancy level.
//   i_clk, i_rst (async, active-high)
//   i_push/i_data  - write port, ignored when full
//   i_pop/o_data   - read port, o_data shows the head entry, pop ignored when empty
//   o_full, o_empty, o_level - registered-state status
module idli_uart_fifo_m #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    always_comb begin
        o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        o_empty = wr_q == rd_q;
        o_level = wr_q - rd_q;
        o_data  = mem_q[rd_q[AW-1:0]];
        wr_d    = (i_push && !o_full) ? wr_q + 1'b1 : wr_q;
        rd_d    = (i_pop && !o_empty) ? rd_q + 1'b1 : rd_q;
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) mem_q[wr_q[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/idli_uart_tx_m.sv
// idli_uart_tx_m: nibble-fed, FIFO-buffered UART transmitter (start, DATA_W bits LSB first, optional even parity, STOP_BITS stop bits).
//   i_utx_gck, i_utx_rst (async, active-high)
//   i_utx_data/i_utx_vld/o_utx_acp - nibble stream, low nibble first, transfer when acp
//   o_utx_level - FIFO occupancy, o_utx_busy - frame in flight or FIFO non-empty
//   o_utx_tx    - registered serial line, idle high
//   Define IDLI_UART_TX_PARITY_EN to insert an even-parity bit between data and stop bits.
module idli_uart_tx_m
    import idli_pkg::*;
#(
    parameter int DATA_W     = UART_DATA_W_DFLT,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = UART_CLK_DIV_DFLT,
    parameter int STOP_BITS  = 1
) (
    input  logic                          i_utx_gck,
    input  logic                          i_utx_rst,
    input  sqi_data_t                     i_utx_data,
    input  logic                          i_utx_vld,
    output logic                          o_utx_acp,
    output logic [$clog2(FIFO_DEPTH):0]   o_utx_level,
    output logic                          o_utx_busy,
    output logic                          o_utx_tx
);
    localparam int NIB = DATA_W / 4;
    localparam int KW  = NIB > 1 ? $clog2(NIB) : 1;
    localparam int BW  = $clog2(CLK_DIV);
    localparam int CW  = $clog2(DATA_W + 1);
    logic [KW-1:0]     k_q, k_d;
    logic [DATA_W-1:0] asm_q, asm_d, char_w, fifo_dout, shift_q, shift_d;
    logic              last, push, pop, fifo_full, fifo_empty, adv, tx_q, tx_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [CW-1:0]     bit_q, bit_d;
    uart_tx_state_t    state_q, state_d;
`ifdef IDLI_UART_TX_PARITY_EN
    logic              par_q, par_d;
`endif
    // Only the character-completing nibble is held back by a full FIFO.
    always_comb begin
        last                 = k_q == KW'(NIB - 1);
        o_utx_acp            = i_utx_vld && !(last && fifo_full);
        char_w               = asm_q;
        char_w[4*k_q +: 4]   = i_utx_data;
        asm_d                = o_utx_acp ? char_w : asm_q;
        k_d                  = o_utx_acp ? (last ? '0 : k_q + 1'b1) : k_q;
        push                 = o_utx_acp && last;
    end
    always_ff @(posedge i_utx_gck or posedge i_utx_rst) begin
        if (i_utx_rst) begin
            k_q   <= '0;
            asm_q <= '0;
        end else begin
            k_q   <= k_d;
            asm_q <= asm_d;
        end
    end
    idli_uart_fifo_m #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_utx_gck),
        .i_rst   (i_utx_rst),
        .i_push  (push),
        .i_data  (char_w),
        .i_pop   (pop),
        .o_data  (fifo_dout),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_level (o_utx_level)
    );
    // tx_d is the line value of the state being entered, so the line changes on the same edge as the state.
    always_comb begin
        adv     = baud_q == '0;
        state_d = state_q;
        baud_d  = adv ? BW'(CLK_DIV - 1) : baud_q - 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = BW'(CLK_DIV - 1);
                pop    = !fifo_empty;
            end
            START: if (adv) begin
                state_d = DATA;
                bit_d   = CW'(DATA_W - 1);
                tx_d    = shift_q[0];
            end
            DATA: if (adv) begin
                if (bit_q != '0) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q - 1'b1;
                    tx_d    = shift_q[1];
                end else begin
`ifdef IDLI_UART_TX_PARITY_EN
                    state_d = PARITY;
                    tx_d    = par_q;
`else
                    state_d = STOP;
                    bit_d   = CW'(STOP_BITS - 1);
                    tx_d    = 1'b1;
`endif
                end
            end
`ifdef IDLI_UART_TX_PARITY_EN
            PARITY: if (adv) begin
                state_d = STOP;
                bit_d   = CW'(STOP_BITS - 1);
                tx_d    = 1'b1;
            end
`endif
            STOP: if (adv) begin
                if (bit_q != '0) begin
                    bit_d = bit_q - 1'b1;
                end else begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    pop     = !fifo_empty;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // A pop from IDLE or the final stop bit starts the next frame with no idle gap.
        if (pop) begin
            state_d = START;
            tx_d    = 1'b0;
            shift_d = fifo_dout;
        end
`ifdef IDLI_UART_TX_PARITY_EN
        par_d = pop ? ^fifo_dout : par_q;
`endif
    end
    always_ff @(posedge i_utx_gck or posedge i_utx_rst) begin
        if (i_utx_rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef IDLI_UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef IDLI_UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
    assign o_utx_tx   = tx_q;
    assign o_utx_busy = (state_q != IDLE) || !fifo_empty;
endmodule

// File: tb/tb_idli_uart_tx_m.sv
// tb_idli_uart_tx_m: directed and randomized checks of idli_uart_tx_m against a frame-level line model.
module tb_idli_uart_tx_m;
    localparam int DW = 8;
    localparam int FD = 4;
    localparam int CD = 4;
`ifdef IDLI_UART_TX_PARITY_EN
    localparam int SB = 2;
    localparam int PB = 1;
`else
    localparam int SB = 1;
    localparam int PB = 0;
`endif
    localparam int FRAME = 1 + DW + PB + SB;

    logic       clk = 1'b0, rst = 1'b1, vld = 1'b0;
    logic [3:0] data = '0;
    logic       acp, busy, tx;
    logic [2:0] level;
    int         checks = 0, failures = 0, cyc = 0, frames_done = 0;
    logic [7:0] exp_q [$];
    int         starts [$];

    idli_uart_tx_m #(.DATA_W(DW), .FIFO_DEPTH(FD), .CLK_DIV(CD), .STOP_BITS(SB)) dut (
        .i_utx_gck   (clk),
        .i_utx_rst   (rst),
        .i_utx_data  (data),
        .i_utx_vld   (vld),
        .o_utx_acp   (acp),
        .o_utx_level (level),
        .o_utx_busy  (busy),
        .o_utx_tx    (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line levels of one frame, one entry per bit time, earliest bit at index 0.
    function automatic logic [31:0] frame_bits(input logic [7:0] c);
        logic [31:0] f = '0;
        for (int i = 0; i < DW; i++) f[1 + i] = c[i];
`ifdef IDLI_UART_TX_PARITY_EN
        f[1 + DW] = ^c;
`endif
        for (int s = 0; s < SB; s++) f[1 + DW + PB + s] = 1'b1;
        return f;
    endfunction

    // Line monitor: a falling line from idle opens a frame; every bit time must hold one level for CD samples.
    int          pos = 0, hold_bad = 0;
    logic [31:0] got, expf;
    always @(negedge clk) begin
        if (rst) begin
            pos = 0;
        end else if (pos == 0) begin
            if (tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                    expf = '1;
                end else begin
                    expf = frame_bits(exp_q.pop_front());
                end
                starts.push_back(cyc);
                got      = '0;
                hold_bad = 0;
                pos      = 1;
            end
        end else begin
            if (pos % CD == 0) got[pos / CD] = tx;
            else if (tx !== got[pos / CD]) hold_bad++;
            pos++;
            if (pos == FRAME * CD) begin
                chk("frame", got, expf);
                chk("bit_hold", hold_bad, 0);
                frames_done++;
                pos = 0;
            end
        end
    end

    task automatic put_nib(input logic [3:0] n, output int acc);
        int w = 0;
        @(negedge clk);
        vld  = 1'b1;
        data = n;
        #1;
        while (!acp && w < 3000) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!acp) chk("acp_timeout", 32'd0, 32'd1);
        acc = cyc;
    endtask

    task automatic put_char(input logic [7:0] c, output int acc);
        put_nib(c[3:0], acc);
        put_nib(c[7:4], acc);
        exp_q.push_back(c);
    endtask

    task automatic drop_vld();
        @(negedge clk);
        vld = 1'b0;
        #1;
    endtask

    task automatic wait_frames(input int n);
        int w = 0;
        while (frames_done < n && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("frames_done", frames_done, n);
    endtask

    task automatic wait_start(input int n);
        int w = 0;
        while (starts.size() < n && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("start_seen", starts.size(), n);
    endtask

    initial begin
        int acc, bad, n0, rise;
        logic [7:0] c;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_acp", acp, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || level !== 3'd0) bad++;
        end
        chk("idle_100", bad, 0);

        // Single character: latency and level trace.
        put_char(8'hA5, acc);
        drop_vld();
        chk("lvl_after_push", level, 1);
        chk("busy_queued", busy, 1);
        @(negedge clk);
        #1;
        chk("lvl_after_pop", level, 0);
        chk("start_bit_line", tx, 0);
        chk("start_latency", starts[0], acc + 2);
        wait_frames(1);

        // Parity-sensitive characters.
        put_char(8'h07, acc);
        drop_vld();
        wait_frames(2);
        put_char(8'h03, acc);
        drop_vld();
        wait_frames(3);
        @(negedge clk);
        chk("idle_after", busy, 0);

        // Busy line, five characters streamed: the last nibble waits for the first pop.
        put_char(8'($urandom), acc);
        drop_vld();
        wait_start(4);
        for (int i = 0; i < 4; i++) put_char(8'($urandom), acc);
        c = 8'($urandom);
        put_nib(c[3:0], acc);
        @(negedge clk);
        data = c[7:4];
        #1;
        chk("acp_full", acp, 0);
        chk("lvl_full", level, 4);
        begin
            int w = 0;
            while (!acp && w < 3000) begin
                @(negedge clk);
                #1;
                w++;
            end
        end
        chk("acp_resume", acp, 1);
        rise = cyc;
        chk("lvl_on_pop", level, 3);
        chk("resume_at_pop", rise, starts[starts.size() - 1]);
        exp_q.push_back(c);
        drop_vld();
        chk("lvl_refill", level, 4);
        wait_frames(9);
        for (int i = 3; i < 8; i++) chk("no_gap", starts[i + 1] - starts[i], FRAME * CD);

        // Reset in the middle of a data bit with two characters queued.
        put_char(8'h00, acc);
        put_char(8'($urandom), acc);
        put_char(8'($urandom), acc);
        drop_vld();
        wait_start(10);
        repeat (CD * 3) @(negedge clk);
        chk("mid_data_low", tx, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_tx", tx, 1);
        chk("rst_async_level", level, 0);
        chk("rst_async_busy", busy, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        n0  = starts.size();
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("post_rst_idle", bad, 0);
        chk("post_rst_no_frame", starts.size(), n0);
        chk("model_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
